// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 memory-port arbiter.
// Holds FSM states, client ids and transaction opcodes.
`timescale 1ns/1ps
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_client_t;

  typedef enum logic {
    ARB_RD,
    ARB_WR
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one cache-line memory port between icache and dcache.
// Round-robin on ties; the granted request is held for the whole transaction.
`timescale 1ns/1ps
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              d_rw_err
);

  arb_state_t  state;
  arb_state_t  state_nx;
  arb_client_t last_gnt;
  arb_op_t     op_q;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic              rw_err_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic busy;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign busy  = (state == I_BUSY) | (state == D_BUSY);

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    unique case (state)
      IDLE: begin
        // icache wins only if alone or if dcache had the last grant
        if (i_req && (!d_req || last_gnt == ARB_D)) begin
          grant_i  = 1'b1;
          state_nx = I_BUSY;
        end else if (d_req) begin
          grant_d  = 1'b1;
          state_nx = D_BUSY;
        end
      end
      I_BUSY: if (mem_resp) state_nx = I_DONE;
      D_BUSY: if (mem_resp) state_nx = D_DONE;
      I_DONE: state_nx = IDLE;
      D_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= ARB_I;
      op_q     <= ARB_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      rw_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_i) begin
        last_gnt <= ARB_I;
        op_q     <= ARB_RD;
        addr_q   <= i_addr;
      end
      if (grant_d) begin
        last_gnt <= ARB_D;
        op_q     <= d_write ? ARB_WR : ARB_RD;
        addr_q   <= d_addr;
        if (d_write) wdata_q <= d_wdata;
      end
      if (busy && mem_resp) line_q <= mem_rdata;
      if (d_read && d_write) rw_err_q <= 1'b1;
    end
  end

  assign mem_read  = busy && (op_q == ARB_RD);
  assign mem_write = busy && (op_q == ARB_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_resp   = (state == I_DONE);
  assign d_resp   = (state == D_DONE);
  assign i_rdata  = line_q;
  assign d_rdata  = line_q;
  assign d_rw_err = rw_err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: random client traffic, a memory
// responder and a reference model of arbitration and line contents.
`timescale 1ns/1ps
module tb_cache_arbiter;

  typedef struct {
    bit           chk;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;
  logic         d_rw_err;

  int vec  = 0;
  int errs = 0;

  exp_t iq[$];
  exp_t dq[$];
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] mem_store [logic [31:0]];

  int           fix_lat = -1;
  bit           ovr_en = 1'b0;
  logic [255:0] ovr_data = '0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .d_rw_err(d_rw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_of(a);
  endfunction

  // downstream memory: variable latency, real storage for writebacks
  int wt = 0;
  bit armed = 1'b0;
  always @(negedge clk) begin
    mem_resp = 1'b0;
    if (rst && (mem_read || mem_write)) begin
      if (!armed) begin
        armed = 1'b1;
        wt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
      end
      if (wt == 0) begin
        armed = 1'b0;
        mem_resp = 1'b1;
        if (mem_write) begin
          mem_store[mem_addr] = mem_wdata;
          mem_rdata = rnd_line();
        end else if (ovr_en) begin
          mem_rdata = ovr_data;
        end else begin
          mem_rdata = mem_store.exists(mem_addr) ?
                      mem_store[mem_addr] : line_of(mem_addr);
        end
      end else begin
        wt--;
      end
    end else begin
      armed = 1'b0;
    end
  end

  // monitor: arbitration model, hold-register check, response scoreboard
  bit           last_d = 1'b0;
  bit           busy_prev = 1'b0;
  bit           own_d;
  bit           p_i = 1'b0, p_d = 1'b0, p_dwr = 1'b0;
  logic [31:0]  p_iaddr = '0, p_daddr = '0, h_addr = '0;
  logic [255:0] p_dwdata = '0, h_wdata = '0;
  bit           h_wr = 1'b0;
  exp_t         e;
  always @(negedge clk) begin
    if (!rst) begin
      last_d = 1'b0;
      busy_prev = 1'b0;
    end else begin
      check("strobe_excl", {255'b0, mem_read & mem_write}, 0);
      if ((mem_read || mem_write) && !busy_prev) begin
        check("grant_has_req", {255'b0, p_i | p_d}, 1);
        own_d   = (p_i && p_d) ? !last_d : p_d;
        h_addr  = own_d ? p_daddr : p_iaddr;
        h_wr    = own_d && p_dwr;
        h_wdata = p_dwdata;
        last_d  = own_d;
      end
      if (mem_read || mem_write) begin
        check("mem_addr", mem_addr, h_addr);
        check("mem_write", {255'b0, mem_write}, {255'b0, h_wr});
        if (h_wr) check("mem_wdata", mem_wdata, h_wdata);
      end
      busy_prev = mem_read || mem_write;
      if (i_resp) begin
        check("i_resp_expected", {255'b0, iq.size() != 0}, 1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          check("i_rdata", i_rdata, e.data);
        end
      end
      if (d_resp) begin
        check("d_resp_expected", {255'b0, dq.size() != 0}, 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          if (e.chk) check("d_rdata", d_rdata, e.data);
        end
      end
    end
    p_i      = i_read;
    p_d      = d_read | d_write;
    p_dwr    = d_write;
    p_iaddr  = i_addr;
    p_daddr  = d_addr;
    p_dwdata = d_wdata;
  end

  task automatic wait_resp(input bit is_d);
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (is_d ? d_resp : i_resp) break;
      n++;
    end
    check(is_d ? "d_resp_timeout" : "i_resp_timeout", {255'b0, n < 300}, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic i_txn(input logic [31:0] a);
    i_addr = a;
    i_read = 1'b1;
    iq.push_back('{1'b1, ref_line(a)});
    wait_resp(1'b0);
    i_read = 1'b0;
  endtask

  task automatic d_txn(input bit rd, input bit wr,
                       input logic [31:0] a, input logic [255:0] w);
    d_addr  = a;
    d_wdata = w;
    d_read  = rd;
    d_write = wr;
    if (wr) begin
      ref_mem[a] = w;
      dq.push_back('{1'b0, '0});
    end else begin
      dq.push_back('{1'b1, ref_line(a)});
    end
    wait_resp(1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [255:0] w;
    int cnt;
    bit got;

    do_reset();
    @(negedge clk);
    check("rst_mem_read", {255'b0, mem_read}, 0);
    check("rst_mem_write", {255'b0, mem_write}, 0);
    check("rst_mem_addr", {224'b0, mem_addr}, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp", {254'b0, i_resp, d_resp}, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_rw_err", {255'b0, d_rw_err}, 0);
    @(posedge clk);
    #1;

    // single icache read, memory answers on the third busy cycle
    fix_lat = 2;
    ovr_en = 1'b1;
    ovr_data = {32{8'hA5}};
    i_addr = 32'h0000_1040;
    i_read = 1'b1;
    iq.push_back('{1'b1, {32{8'hA5}}});
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem_read) cnt++;
      if (i_resp) got = 1'b1;
    end
    check("d1_resp_seen", {255'b0, got}, 1);
    check("d1_read_cycles", 256'(cnt), 3);
    check("d1_no_d_resp", {255'b0, d_resp}, 0);
    @(posedge clk);
    #1;
    i_read = 1'b0;
    @(negedge clk);
    check("d1_resp_one_cycle", {255'b0, i_resp}, 0);
    ovr_en = 1'b0;
    @(posedge clk);
    #1;

    // tie after reset: dcache first; its inputs move during D_BUSY
    do_reset();
    fix_lat = 3;
    w = rnd_line();
    fork
      i_txn(32'h0000_0100);
      d_txn(1'b0, 1'b1, 32'h0000_0200, w);
      begin
        int n = 0;
        while (!mem_write && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("tie_d_first", {255'b0, mem_write}, 1);
        d_addr = 32'h0000_03E0;
        d_wdata = ~w;
        @(negedge clk);
        check("hold_addr", {224'b0, mem_addr}, 32'h0000_0200);
        check("hold_wdata", mem_wdata, w);
      end
    join

    // reset in the middle of an icache fill
    fix_lat = 20;
    i_addr = 32'h0001_0200;
    i_read = 1'b1;
    cnt = 0;
    while (!mem_read && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("rm_busy", {255'b0, mem_read}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rm_read_drop", {255'b0, mem_read}, 0);
    check("rm_no_resp", {255'b0, i_resp}, 0);
    fix_lat = -1;
    iq.push_back('{1'b1, ref_line(32'h0001_0200)});
    wait_resp(1'b0);
    i_read = 1'b0;

    // random concurrent traffic from both clients
    do_reset();
    fork
      for (int n = 0; n < 30; n++) begin
        repeat (n == 0 ? 0 : $urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        i_txn(32'h0001_0000 | ($urandom_range(0, 15) << 5));
      end
      for (int n = 0; n < 30; n++) begin
        bit wr;
        repeat (n == 0 ? 0 : $urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        wr = $urandom_range(0, 1) == 1;
        d_txn(!wr, wr, 32'h0002_0000 | ($urandom_range(0, 7) << 5),
              rnd_line());
      end
    join
    check("rand_rw_err", {255'b0, d_rw_err}, 0);

    // conflicting read+write is a write and sets the sticky error
    d_txn(1'b1, 1'b1, 32'h0002_0020, rnd_line());
    check("rw_err_set", {255'b0, d_rw_err}, 1);
    d_txn(1'b1, 1'b0, 32'h0002_0020, '0);
    repeat (4) @(posedge clk);
    #1;
    check("rw_err_sticky", {255'b0, d_rw_err}, 1);
    do_reset();
    @(negedge clk);
    check("rw_err_cleared", {255'b0, d_rw_err}, 0);

    repeat (5) @(posedge clk);
    check("iq_drained", 256'(iq.size()), 0);
    check("dq_drained", 256'(dq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
